// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Byte-stream boot loader sitting directly in front of the CPU instruction
//   memory. It receives a length-prefixed program over a valid/ready byte
//   handshake, packs pairs of bytes (high byte first) into instruction words,
//   writes them to consecutive imem addresses starting at 0, and holds the CPU
//   in reset until the whole program has arrived.
//
//   Byte stream: N, then N words of 2 bytes each (N = 1 .. 2^ADDR_W).
//   Optional feature macro IMEM_LOADER_CHECKSUM_EN: one extra trailing byte
//   must equal the XOR of the count byte and every instruction byte, or the
//   load ends in the error state.
//
// Ports:
//   clk         system clock
//   rst         synchronous reset, active-high
//   rx_data     incoming byte
//   rx_valid    rx_data is valid
//   rx_ready    loader accepts a byte this cycle (registered)
//   start       one-cycle pulse; restarts a load from DONE or ERR
//   imem_we     one-cycle imem write strobe
//   imem_addr   imem write address (holds its last value between writes)
//   imem_wdata  imem write data (holds its last value between writes)
//   cpu_rst_n   active-low CPU reset; released only once the load is done
//   load_done   program loaded, CPU running
//   load_err    load aborted (bad count, timeout or checksum mismatch)
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              start,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_rst_n,
    output logic              load_done,
    output logic              load_err
);

    // The word count needs one bit more than the address so 2^ADDR_W fits.
    localparam int CNT_W = ADDR_W + 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HI   = 3'd1,
        LO   = 3'd2,
        CHK  = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    state_t              state_r;
    logic [CNT_W-1:0]    n_r;
    logic [ADDR_W-1:0]   word_idx_r;
    logic [7:0]          hi_r;
    logic [TO_W-1:0]     to_cnt_r;

    logic                accept_s;
    logic                timing_s;
    logic                timeout_s;
    logic                count_bad_s;
    logic                last_word_s;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          chk_r;

    // Running XOR checksum over the count byte and every instruction byte.
    function automatic logic [7:0] chk_next(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction
`endif

    // Decode handshake, timeout, count validity and last-word conditions.
    always_comb begin
        accept_s    = rx_valid && rx_ready;
        timing_s    = 1'b0;
        count_bad_s = 1'b0;
        case (state_r)
            HI, LO, CHK: timing_s = 1'b1;
            default:     timing_s = 1'b0;
        endcase
        if ((rx_data == 8'd0) || ({24'd0, rx_data} > (32'd1 << ADDR_W))) begin
            count_bad_s = 1'b1;
        end else begin
            count_bad_s = 1'b0;
        end
        timeout_s   = timing_s && !accept_s && (to_cnt_r == TO_LAST);
        last_word_s = ({1'b0, word_idx_r} == (n_r - CNT_W'(1'b1)));
    end

    // Loader FSM with all outputs registered; rx_ready tracks the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            rx_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= {ADDR_W{1'b0}};
            imem_wdata <= {DATA_W{1'b0}};
            cpu_rst_n  <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            n_r        <= {CNT_W{1'b0}};
            word_idx_r <= {ADDR_W{1'b0}};
            hi_r       <= 8'd0;
            to_cnt_r   <= {TO_W{1'b0}};
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_r      <= 8'd0;
`endif
        end else begin
            imem_we <= 1'b0;

            // Inter-byte idle timer: runs only while a load is in progress.
            if (accept_s || !timing_s) begin
                to_cnt_r <= {TO_W{1'b0}};
            end else if (!timeout_s) begin
                to_cnt_r <= to_cnt_r + TO_W'(1'b1);
            end else begin
                to_cnt_r <= to_cnt_r;
            end

            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        if (count_bad_s) begin
                            state_r  <= ERR;
                            rx_ready <= 1'b0;
                        end else begin
                            n_r        <= CNT_W'(rx_data);
                            word_idx_r <= {ADDR_W{1'b0}};
                            state_r    <= HI;
                            rx_ready   <= 1'b1;
                        end
`ifdef IMEM_LOADER_CHECKSUM_EN
                        chk_r <= rx_data;
`endif
                    end else begin
                        rx_ready <= 1'b1;
                    end
                end

                HI: begin
                    if (accept_s) begin
                        hi_r    <= rx_data;
                        state_r <= LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        chk_r   <= chk_next(chk_r, rx_data);
`endif
                    end else if (timeout_s) begin
                        state_r  <= ERR;
                        rx_ready <= 1'b0;
                    end else begin
                        state_r <= HI;
                    end
                end

                LO: begin
                    if (accept_s) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= word_idx_r;
                        imem_wdata <= DATA_W'({hi_r, rx_data});
`ifdef IMEM_LOADER_CHECKSUM_EN
                        chk_r      <= chk_next(chk_r, rx_data);
`endif
                        if (last_word_s) begin
                            // Index stays at N-1 so it never wraps past the program.
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_r  <= CHK;
                            rx_ready <= 1'b1;
`else
                            state_r  <= DONE;
                            rx_ready <= 1'b0;
`endif
                        end else begin
                            word_idx_r <= word_idx_r + ADDR_W'(1'b1);
                            state_r    <= HI;
                        end
                    end else if (timeout_s) begin
                        state_r  <= ERR;
                        rx_ready <= 1'b0;
                    end else begin
                        state_r <= LO;
                    end
                end

                CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (accept_s) begin
                        state_r  <= (rx_data == chk_r) ? DONE : ERR;
                        rx_ready <= 1'b0;
                    end else if (timeout_s) begin
                        state_r  <= ERR;
                        rx_ready <= 1'b0;
                    end else begin
                        state_r <= CHK;
                    end
`else
                    // Unreachable without the checksum feature; fail safe.
                    state_r  <= ERR;
                    rx_ready <= 1'b0;
`endif
                end

                DONE: begin
                    if (start) begin
                        state_r   <= IDLE;
                        rx_ready  <= 1'b1;
                        load_done <= 1'b0;
                        load_err  <= 1'b0;
                        cpu_rst_n <= 1'b0;
                    end else begin
                        load_done <= 1'b1;
                        cpu_rst_n <= 1'b1;
                    end
                end

                ERR: begin
                    if (start) begin
                        state_r   <= IDLE;
                        rx_ready  <= 1'b1;
                        load_done <= 1'b0;
                        load_err  <= 1'b0;
                        cpu_rst_n <= 1'b0;
                    end else begin
                        load_err  <= 1'b1;
                        cpu_rst_n <= 1'b0;
                    end
                end

                default: begin
                    state_r   <= ERR;
                    rx_ready  <= 1'b0;
                    cpu_rst_n <= 1'b0;
                end
            endcase
        end
    end

endmodule
